// File: rtl/wasm_leb_pkg.sv
// Shared types and constants for the LEB128 immediate fetch stage.
package wasm_leb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DECODE,
    ST_DONE
  } leb_state_e;

  typedef enum logic [1:0] {
    LEB_OK    = 2'd0,
    LEB_MEM   = 2'd1,
    LEB_RANGE = 2'd2,
    LEB_NO64  = 2'd3
  } leb_err_e;

  localparam int unsigned LEB_MAX32 = 5;
  localparam int unsigned LEB_MAX64 = 10;

  // Keeps only the bits that belong to the target integer width.
  function automatic logic [63:0] width_mask(input logic is_64);
    return is_64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

endpackage

// File: rtl/leb128_fetch_if.sv
// Instruction ROM window port: address out, window data and bound error back.
interface leb128_fetch_if #(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4
);

  logic [MEM_DEPTH:0]          mem_addr;
  logic [MEM_EXTRA-1:0]        mem_extra;
  logic [(2**MEM_EXTRA)*8-1:0] mem_data;
  logic                        mem_error;

  modport master (
    output mem_addr,
    output mem_extra,
    input  mem_data,
    input  mem_error
  );

  modport slave (
    input  mem_addr,
    input  mem_extra,
    output mem_data,
    output mem_error
  );

endinterface

// File: rtl/leb_final_check.sv
// Final-byte legality checks and sign-extension mask for one LEB128 byte.
module leb_final_check
  import wasm_leb_pkg::*;
(
  input  logic [7:0]  byte_in,
  input  logic [3:0]  byte_num,
  input  logic        is_signed,
  input  logic        is_64,
  output logic        overlong,
  output logic        range_err,
  output logic [63:0] sext_mask
);

  logic       at_limit;
  logic [6:0] ext_shift;

  always_comb begin
    at_limit  = is_64 ? (byte_num == 4'(LEB_MAX64)) : (byte_num == 4'(LEB_MAX32));
    overlong  = byte_in[7] & at_limit;
    range_err = 1'b0;
    ext_shift = 7'(byte_num) * 7'd7;
    sext_mask = '0;

    // The last permitted byte may only carry bits that still fit the target width.
    if (!byte_in[7] && at_limit) begin
      if (is_64) begin
        range_err = is_signed ? !((byte_in[6:0] == 7'h00) || (byte_in[6:0] == 7'h7F))
                              : (byte_in[6:1] != 6'd0);
      end else begin
        range_err = is_signed ? (byte_in[6:4] != {3{byte_in[3]}})
                              : (byte_in[6:4] != 3'd0);
      end
    end

    if (is_signed && !byte_in[7] && byte_in[6]) begin
      sext_mask = (64'hFFFF_FFFF_FFFF_FFFF << ext_shift) & width_mask(is_64);
    end
  end

endmodule

// File: rtl/leb128_fetch.sv
// Fetches a ROM window at a program counter and decodes one WebAssembly LEB128
// immediate from it, one byte per cycle.
module leb128_fetch
  import wasm_leb_pkg::*;
#(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4,
  parameter bit USE_64B   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MEM_DEPTH:0] start_pc,
  input  logic               is_signed,
  input  logic               is_64,
  output logic               busy,
  output logic               done,
  output logic [63:0]        value,
  output logic [MEM_DEPTH:0] next_pc,
  output logic [1:0]         error,
  leb128_fetch_if.master     mem
);

  localparam int AW       = MEM_DEPTH + 1;
  localparam int WIN_BITS = (2 ** MEM_EXTRA) * 8;

  leb_state_e          state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW-1:0]       mem_addr_c;
  logic                signed_q, signed_d;
  logic                is64_q, is64_d;
  logic [WIN_BITS-1:0] win_q, win_d;
  logic [63:0]         acc_q, acc_d;
  logic [3:0]          idx_q, idx_d;
  logic [63:0]         value_q, value_d;
  logic [AW-1:0]       next_pc_q, next_pc_d;
  leb_err_e            error_q, error_d;

  logic [7:0]          cur_byte;
  logic [3:0]          idx_inc;
  logic [6:0]          shamt;
  logic [63:0]         acc_next;
  logic                overlong;
  logic                range_err;
  logic [63:0]         sext_mask;

  // The window is shifted up one byte per decode cycle, so the current byte is always on top.
  assign cur_byte = win_q[WIN_BITS-1 -: 8];
  assign idx_inc  = idx_q + 4'd1;
  assign shamt    = 7'(idx_q) * 7'd7;
  assign acc_next = acc_q | (64'(cur_byte[6:0]) << shamt);

  leb_final_check u_check (
    .byte_in   (cur_byte),
    .byte_num  (idx_inc),
    .is_signed (signed_q),
    .is_64     (is64_q),
    .overlong  (overlong),
    .range_err (range_err),
    .sext_mask (sext_mask)
  );

  // DONE also accepts a request so a new decode can launch on the edge done drops.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    signed_d   = signed_q;
    is64_d     = is64_q;
    win_d      = win_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    value_d    = value_q;
    next_pc_d  = next_pc_q;
    error_d    = error_q;
    mem_addr_c = addr_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          if (is_64 && !USE_64B) begin
            state_d   = ST_DONE;
            error_d   = LEB_NO64;
            value_d   = '0;
            next_pc_d = start_pc;
          end else begin
            state_d    = ST_WAIT;
            pc_d       = start_pc;
            addr_d     = start_pc;
            signed_d   = is_signed;
            is64_d     = is_64;
            mem_addr_c = start_pc;
          end
        end
      end

      ST_WAIT: begin
        win_d = mem.mem_data;
        acc_d = '0;
        idx_d = '0;
        if (mem.mem_error) begin
          state_d   = ST_DONE;
          error_d   = LEB_MEM;
          value_d   = '0;
          next_pc_d = pc_q;
        end else begin
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        acc_d = acc_next;
        idx_d = idx_inc;
        win_d = win_q << 8;
        if (overlong || (!cur_byte[7] && range_err)) begin
          state_d   = ST_DONE;
          error_d   = LEB_RANGE;
          value_d   = '0;
          next_pc_d = pc_q + AW'(idx_inc);
        end else if (!cur_byte[7]) begin
          state_d   = ST_DONE;
          error_d   = LEB_OK;
          value_d   = (acc_next | sext_mask) & width_mask(is64_q);
          next_pc_d = pc_q + AW'(idx_inc);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      addr_q    <= '0;
      signed_q  <= 1'b0;
      is64_q    <= 1'b0;
      win_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      value_q   <= '0;
      next_pc_q <= '0;
      error_q   <= LEB_OK;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      signed_q  <= signed_d;
      is64_q    <= is64_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      value_q   <= value_d;
      next_pc_q <= next_pc_d;
      error_q   <= error_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign value         = value_q;
  assign next_pc       = next_pc_q;
  assign error         = error_q;
  assign mem.mem_addr  = mem_addr_c;
  assign mem.mem_extra = '1;

endmodule
